wb_cp0: RTL and testbench
=========================

WB_CP0 -- requirements
Module: wb_cp0

Interface
REQ-001 SHALL have parameter EXC_VECTOR, default 32'hBFC0_0380, exception entry address.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port WB_valid  input  1  WB stage holds a valid instruction.
REQ-005 SHALL have port MEM_WB_bus_r  input  73  fields: [72] exc_flag, [71:70] exc_type, [69] wen, [68:64] wdest, [63:32] wdata, [31:0] pc.
REQ-006 SHALL have port wb_eret  input  1  instruction in WB is ERET.
REQ-007 SHALL have port rf_wen  output  1  register-file write enable.
REQ-008 SHALL have port rf_wdest  output  5  register-file write address.
REQ-009 SHALL have port rf_wdata  output  32  register-file write data.
REQ-010 SHALL have port WB_over  output  1  WB stage finished this cycle.
REQ-011 SHALL have port WB_pc  output  32  PC of instruction in WB.
REQ-012 SHALL have port exc_redirect  output  1  one-cycle fetch redirect pulse.
REQ-013 SHALL have port redirect_pc  output  32  redirect target.
REQ-014 SHALL have ports cp0_status, cp0_cause, cp0_epc, cp0_count  output  32 each  CP0 register values.

Function
REQ-015 SHALL implement FSM states IDLE, EXC_REC, REDIR; reset state IDLE.
REQ-016 IDLE, WB_valid=1, exc_flag=0, wb_eret=0: SHALL drive rf_wen=wen, rf_wdest=wdest, rf_wdata=wdata, WB_over=1 same cycle; remain IDLE.
REQ-017 rf_wen SHALL be 0 whenever WB_valid=0, exc_flag=1, wdest=0, or state != IDLE.
REQ-018 IDLE, WB_valid=1, exc_flag=1: SHALL go to EXC_REC, WB_over=0, no register write.
REQ-019 EXC_REC: if cp0_status[1] (EXL)=0, SHALL load cp0_epc=pc and set EXL=1; if EXL=1, SHALL leave EPC unchanged; SHALL write cp0_cause[6:2] ExcCode per exc_type 00->4 (AdEL), 01->5 (AdES), 10->8 (Sys), 11->12 (Ov); go REDIR.
REQ-020 REDIR: SHALL assert exc_redirect=1, redirect_pc=EXC_VECTOR, WB_over=1 for exactly one cycle; return IDLE.
REQ-021 Exception latency: bus capture to exc_redirect SHALL be exactly 2 cycles (IDLE->EXC_REC->REDIR).
REQ-022 IDLE, WB_valid=1, wb_eret=1, exc_flag=0: SHALL assert exc_redirect=1, redirect_pc=cp0_epc (pre-update value), WB_over=1 same cycle, clear EXL at clock edge; no register write.
REQ-023 Simultaneous exc_flag=1 and wb_eret=1: exception SHALL win; ERET ignored.
REQ-024 MEM_WB_bus_r fields SHALL be latched on IDLE->EXC_REC; EXC_REC/REDIR SHALL use latched pc/exc_type regardless of input changes.
REQ-025 WB_valid SHALL be ignored in EXC_REC and REDIR; WB_pc SHALL show latched pc in those states, bus pc otherwise.
REQ-026 cp0_count SHALL increment by 1 every second clock (internal toggle), wrapping 32'hFFFF_FFFF -> 0.
REQ-027 cp0_status SHALL have all bits except [1] hard-wired 0; cp0_cause bits outside [6:2] hard-wired 0.
REQ-028 exc_redirect SHALL be 0 and redirect_pc SHALL be 0 when no redirect is asserted.

Reset
REQ-029 resetn=0 SHALL asynchronously force state IDLE, cp0_status=0, cp0_cause=0, cp0_epc=0, cp0_count=0, count toggle=0.
REQ-030 Under reset SHALL drive rf_wen=0, WB_over=0, exc_redirect=0, redirect_pc=0.
REQ-031 Reset asserted in EXC_REC or REDIR SHALL abort the sequence; no redirect pulse after release.

Verification
REQ-032 Normal write: WB_valid=1, bus wen=1, wdest=5, wdata=32'h1234_5678 -> same cycle rf_wen=1, rf_wdest=5, rf_wdata=32'h1234_5678, WB_over=1.
REQ-033 $0 write: wen=1, wdest=0 -> rf_wen=0, WB_over=1.
REQ-034 AdES: exc_flag=1, exc_type=01, pc=32'h0000_0040, EXL=0 -> 2 cycles later exc_redirect=1, redirect_pc=32'hBFC0_0380; cp0_epc=32'h0000_0040, cp0_cause[6:2]=5, cp0_status[1]=1.
REQ-035 Nested: second exception exc_type=11 at pc=32'h80 with EXL=1 -> cp0_epc stays 32'h40, cause[6:2]=12, redirect still issued.
REQ-036 ERET: EPC=32'h40, EXL=1, wb_eret=1 -> same cycle exc_redirect=1, redirect_pc=32'h40; next cycle EXL=0.
REQ-037 Reset in EXC_REC, and count wrap: preload behaviour via 2^33 cycles not required; check count = n/2 after n cycles from reset and no redirect after mid-sequence reset.

Source files
------------

// File: rtl/wb_cp0.sv
// wb_cp0: write-back stage with a minimal CP0 exception unit.
// Retires normal instructions to the register file in the same cycle.
// Sequences exceptions IDLE -> EXC_REC -> REDIR and handles ERET returns.
// Maintains the Status(EXL), Cause(ExcCode), EPC and Count registers.
//
// Ports:
//   clk, resetn           clock, asynchronous active-low reset
//   WB_valid              WB stage holds a valid instruction
//   MEM_WB_bus_r[72:0]    {exc_flag, exc_type[1:0], wen, wdest[4:0], wdata[31:0], pc[31:0]}
//   wb_eret               instruction in WB is ERET
//   rf_wen/wdest/wdata    register-file write port
//   WB_over               WB stage finished this cycle
//   WB_pc                 PC of the instruction in WB
//   exc_redirect          one-cycle fetch redirect pulse
//   redirect_pc           redirect target
//   cp0_status/cause/epc/count  CP0 register values
module wb_cp0 #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        WB_valid,
  input  logic [72:0] MEM_WB_bus_r,
  input  logic        wb_eret,
  output logic        rf_wen,
  output logic [4:0]  rf_wdest,
  output logic [31:0] rf_wdata,
  output logic        WB_over,
  output logic [31:0] WB_pc,
  output logic        exc_redirect,
  output logic [31:0] redirect_pc,
  output logic [31:0] cp0_status,
  output logic [31:0] cp0_cause,
  output logic [31:0] cp0_epc,
  output logic [31:0] cp0_count
);

  localparam int unsigned XLEN    = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned CODE_W  = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXC_REC = 2'd1,
    REDIR   = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Bus field split
  logic              bus_exc_flag;
  logic [1:0]        bus_exc_type;
  logic              bus_wen;
  logic [REG_AW-1:0] bus_wdest;
  logic [XLEN-1:0]   bus_wdata;
  logic [XLEN-1:0]   bus_pc;

  assign bus_exc_flag = MEM_WB_bus_r[72];
  assign bus_exc_type = MEM_WB_bus_r[71:70];
  assign bus_wen      = MEM_WB_bus_r[69];
  assign bus_wdest    = MEM_WB_bus_r[68:64];
  assign bus_wdata    = MEM_WB_bus_r[63:32];
  assign bus_pc       = MEM_WB_bus_r[31:0];

  // Exception context captured on entry to EXC_REC
  logic [XLEN-1:0] lat_pc;
  logic [1:0]      lat_exc_type;

  // CP0 architectural state
  logic              status_exl;
  logic [CODE_W-1:0] cause_code;
  logic [XLEN-1:0]   epc_q;
  logic [XLEN-1:0]   count_q;
  logic              count_tog;

  logic              take_exc;
  logic              take_eret;
  logic [CODE_W-1:0] exc_code;

  assign take_exc  = (state == IDLE) && WB_valid && bus_exc_flag;
  assign take_eret = (state == IDLE) && WB_valid && wb_eret && !bus_exc_flag;

  // ExcCode mapping of the latched exception type
  always_comb begin
    exc_code = CODE_W'(4);
    unique case (lat_exc_type)
      2'b00: exc_code = CODE_W'(4);
      2'b01: exc_code = CODE_W'(5);
      2'b10: exc_code = CODE_W'(8);
      2'b11: exc_code = CODE_W'(12);
      default: exc_code = CODE_W'(4);
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and outputs; everything is held quiet while in reset
  always_comb begin
    state_nxt    = state;
    rf_wen       = 1'b0;
    rf_wdest     = bus_wdest;
    rf_wdata     = bus_wdata;
    WB_over      = 1'b0;
    exc_redirect = 1'b0;
    redirect_pc  = '0;

    unique case (state)
      IDLE: begin
        if (WB_valid) begin
          if (bus_exc_flag) begin
            state_nxt = EXC_REC;
          end else if (wb_eret) begin
            exc_redirect = 1'b1;
            redirect_pc  = epc_q;
            WB_over      = 1'b1;
          end else begin
            rf_wen  = bus_wen && (bus_wdest != '0);
            WB_over = 1'b1;
          end
        end
      end
      EXC_REC: begin
        state_nxt = REDIR;
      end
      REDIR: begin
        exc_redirect = 1'b1;
        redirect_pc  = EXC_VECTOR;
        WB_over      = 1'b1;
        state_nxt    = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (!resetn) begin
      rf_wen       = 1'b0;
      WB_over      = 1'b0;
      exc_redirect = 1'b0;
      redirect_pc  = '0;
    end
  end

  // Exception context latch
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lat_pc       <= '0;
      lat_exc_type <= '0;
    end else if (take_exc) begin
      lat_pc       <= bus_pc;
      lat_exc_type <= bus_exc_type;
    end
  end

  // Status.EXL, Cause.ExcCode and EPC updates
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      status_exl <= 1'b0;
      cause_code <= '0;
      epc_q      <= '0;
    end else if (state == EXC_REC) begin
      // EPC only captured for a non-nested exception
      if (!status_exl) begin
        epc_q      <= lat_pc;
        status_exl <= 1'b1;
      end
      cause_code <= exc_code;
    end else if (take_eret) begin
      status_exl <= 1'b0;
    end
  end

  // Count advances on every second clock
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_tog <= 1'b0;
      count_q   <= '0;
    end else begin
      count_tog <= !count_tog;
      if (count_tog) begin
        count_q <= count_q + XLEN'(1);
      end
    end
  end

  assign WB_pc      = (state == IDLE) ? bus_pc : lat_pc;
  assign cp0_status = {30'd0, status_exl, 1'b0};
  assign cp0_cause  = {25'd0, cause_code, 2'b00};
  assign cp0_epc    = epc_q;
  assign cp0_count  = count_q;

endmodule

// File: tb/tb_wb_cp0.sv
module tb_wb_cp0;

  logic        clk;
  logic        resetn;
  logic        WB_valid;
  logic [72:0] MEM_WB_bus_r;
  logic        wb_eret;
  logic        rf_wen;
  logic [4:0]  rf_wdest;
  logic [31:0] rf_wdata;
  logic        WB_over;
  logic [31:0] WB_pc;
  logic        exc_redirect;
  logic [31:0] redirect_pc;
  logic [31:0] cp0_status;
  logic [31:0] cp0_cause;
  logic [31:0] cp0_epc;
  logic [31:0] cp0_count;

  int checks = 0;
  int errors = 0;

  wb_cp0 dut (
    .clk          (clk),
    .resetn       (resetn),
    .WB_valid     (WB_valid),
    .MEM_WB_bus_r (MEM_WB_bus_r),
    .wb_eret      (wb_eret),
    .rf_wen       (rf_wen),
    .rf_wdest     (rf_wdest),
    .rf_wdata     (rf_wdata),
    .WB_over      (WB_over),
    .WB_pc        (WB_pc),
    .exc_redirect (exc_redirect),
    .redirect_pc  (redirect_pc),
    .cp0_status   (cp0_status),
    .cp0_cause    (cp0_cause),
    .cp0_epc      (cp0_epc),
    .cp0_count    (cp0_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Drive at the falling edge, leaving time for combinational outputs to settle
  task automatic drive(input logic v, input logic ef, input logic [1:0] et, input logic wen,
                       input logic [4:0] wd, input logic [31:0] wdat, input logic [31:0] pc,
                       input logic eret);
    @(negedge clk);
    WB_valid     = v;
    MEM_WB_bus_r = {ef, et, wen, wd, wdat, pc};
    wb_eret      = eret;
    #1;
  endtask

  task automatic idle_bus();
    drive(1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    resetn       = 1'b0;
    WB_valid     = 1'b1;
    MEM_WB_bus_r = {1'b0, 2'b00, 1'b1, 5'd9, 32'hDEAD_BEEF, 32'h0000_0200};
    wb_eret      = 1'b0;

    // Reset quiets outputs even with a valid write on the bus
    repeat (3) @(negedge clk);
    #1;
    check("rst_rf_wen", 32'(rf_wen), 32'd0);
    check("rst_wb_over", 32'(WB_over), 32'd0);
    check("rst_redirect", 32'(exc_redirect), 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'h0);
    check("rst_status", cp0_status, 32'h0);
    check("rst_cause", cp0_cause, 32'h0);
    check("rst_epc", cp0_epc, 32'h0);
    check("rst_count", cp0_count, 32'h0);

    // Release reset and count half-rate
    WB_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("count_10", cp0_count, 32'd5);
    repeat (7) @(negedge clk);
    #1;
    check("count_17", cp0_count, 32'd8);

    // Normal write
    drive(1'b1, 1'b0, 2'b00, 1'b1, 5'd5, 32'h1234_5678, 32'h0000_0100, 1'b0);
    check("wr_rf_wen", 32'(rf_wen), 32'd1);
    check("wr_rf_wdest", 32'(rf_wdest), 32'd5);
    check("wr_rf_wdata", rf_wdata, 32'h1234_5678);
    check("wr_wb_over", 32'(WB_over), 32'd1);
    check("wr_wb_pc", WB_pc, 32'h0000_0100);
    check("wr_redirect", 32'(exc_redirect), 32'd0);
    check("wr_redirect_pc", redirect_pc, 32'h0);

    // $0 write suppressed
    drive(1'b1, 1'b0, 2'b00, 1'b1, 5'd0, 32'hAAAA_5555, 32'h0000_0104, 1'b0);
    check("r0_rf_wen", 32'(rf_wen), 32'd0);
    check("r0_wb_over", 32'(WB_over), 32'd1);

    // wen=0
    drive(1'b1, 1'b0, 2'b00, 1'b0, 5'd3, 32'h1, 32'h0000_0108, 1'b0);
    check("nowen_rf_wen", 32'(rf_wen), 32'd0);

    // Not valid
    drive(1'b0, 1'b0, 2'b00, 1'b1, 5'd3, 32'h1, 32'h0000_010C, 1'b0);
    check("inv_rf_wen", 32'(rf_wen), 32'd0);
    check("inv_wb_over", 32'(WB_over), 32'd0);

    // AdES exception with EXL=0
    drive(1'b1, 1'b1, 2'b01, 1'b1, 5'd4, 32'h7, 32'h0000_0040, 1'b0);
    check("ades_cap_rf_wen", 32'(rf_wen), 32'd0);
    check("ades_cap_wb_over", 32'(WB_over), 32'd0);
    check("ades_cap_redirect", 32'(exc_redirect), 32'd0);
    // EXC_REC: bus changes must not matter
    drive(1'b1, 1'b0, 2'b00, 1'b1, 5'd6, 32'h9, 32'h0000_0999, 1'b0);
    check("ades_rec_wb_pc", WB_pc, 32'h0000_0040);
    check("ades_rec_redirect", 32'(exc_redirect), 32'd0);
    check("ades_rec_wb_over", 32'(WB_over), 32'd0);
    check("ades_rec_rf_wen", 32'(rf_wen), 32'd0);
    // REDIR
    drive(1'b1, 1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0000_0888, 1'b0);
    check("ades_redirect", 32'(exc_redirect), 32'd1);
    check("ades_redirect_pc", redirect_pc, 32'hBFC0_0380);
    check("ades_wb_over", 32'(WB_over), 32'd1);
    check("ades_wb_pc", WB_pc, 32'h0000_0040);
    check("ades_epc", cp0_epc, 32'h0000_0040);
    check("ades_cause", cp0_cause, 32'h0000_0014);
    check("ades_status", cp0_status, 32'h0000_0002);
    idle_bus();
    check("ades_after_redirect", 32'(exc_redirect), 32'd0);

    // Nested Ov with EXL=1
    drive(1'b1, 1'b1, 2'b11, 1'b0, 5'd0, 32'h0, 32'h0000_0080, 1'b0);
    idle_bus();
    idle_bus();
    check("nest_redirect", 32'(exc_redirect), 32'd1);
    check("nest_redirect_pc", redirect_pc, 32'hBFC0_0380);
    check("nest_epc", cp0_epc, 32'h0000_0040);
    check("nest_cause", cp0_cause, 32'h0000_0030);
    check("nest_status", cp0_status, 32'h0000_0002);

    // ERET returns to pre-update EPC, then clears EXL
    drive(1'b1, 1'b0, 2'b00, 1'b1, 5'd7, 32'h5, 32'h0000_0044, 1'b1);
    check("eret_redirect", 32'(exc_redirect), 32'd1);
    check("eret_redirect_pc", redirect_pc, 32'h0000_0040);
    check("eret_wb_over", 32'(WB_over), 32'd1);
    check("eret_rf_wen", 32'(rf_wen), 32'd0);
    check("eret_status_before", cp0_status, 32'h0000_0002);
    idle_bus();
    check("eret_status_after", cp0_status, 32'h0);
    check("eret_redirect_off", 32'(exc_redirect), 32'd0);

    // Exception and ERET together: exception wins
    drive(1'b1, 1'b1, 2'b10, 1'b0, 5'd0, 32'h0, 32'h0000_0050, 1'b1);
    check("both_redirect", 32'(exc_redirect), 32'd0);
    check("both_wb_over", 32'(WB_over), 32'd0);
    idle_bus();
    idle_bus();
    check("both_redirect2", 32'(exc_redirect), 32'd1);
    check("both_redirect_pc", redirect_pc, 32'hBFC0_0380);
    check("both_epc", cp0_epc, 32'h0000_0050);
    check("both_cause", cp0_cause, 32'h0000_0020);
    check("both_status", cp0_status, 32'h0000_0002);

    // Reset during EXC_REC aborts the sequence
    drive(1'b1, 1'b1, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0000_0060, 1'b0);
    @(negedge clk);
    WB_valid = 1'b0;
    resetn   = 1'b0;
    #1;
    check("mid_rst_redirect", 32'(exc_redirect), 32'd0);
    check("mid_rst_status", cp0_status, 32'h0);
    check("mid_rst_epc", cp0_epc, 32'h0);
    check("mid_rst_cause", cp0_cause, 32'h0);
    check("mid_rst_count", cp0_count, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("post_rst_redirect", 32'(exc_redirect), 32'd0);
      check("post_rst_wb_over", 32'(WB_over), 32'd0);
    end
    check("post_rst_count", cp0_count, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
